// File: rtl/seg_scan_dec.sv
// Scanned 7-segment display decoder: synchronizes the multiplexed bus, debounces it,
// rebuilds six-digit frames and derives a binary mm:ss reading from committed frames.
module seg_scan_dec #(
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  i_seg,
    input  logic        i_seg_dp,
    input  logic [5:0]  i_seg_enb,
    output logic [23:0] o_digits,
    output logic [5:0]  o_dp,
    output logic [5:0]  o_sec,
    output logic [5:0]  o_min,
    output logic        o_time_ok,
    output logic        o_frame_done,
    output logic        o_frame_valid,
    output logic        o_err
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam logic [SW-1:0] SETTLE_V  = SW'(SETTLE);
    localparam logic [SW-1:0] SETTLE_M1 = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TMAX      = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMAX_M1   = TW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE,
        COLLECT
    } state_t;

    logic [6:0] seg_s1, seg_s2, seg_prev;
    logic       dp_s1, dp_s2, dp_prev;
    logic [5:0] enb_s1, enb_s2, enb_prev;

    logic [SW-1:0] stab_cnt;
    logic          stable;
    logic          capture;

    logic [3:0] seg_code;
    logic       seg_bad;
    logic [2:0] idx;
    logic [2:0] zeros;
    logic       blank;
    logic       multi;

    state_t     state, state_nxt;
    logic [2:0] exp_idx, exp_nxt;
    logic       store;
    logic       err_nxt;
    logic       commit_nxt;
    logic       commit_pend;

    logic [5:0][3:0] shadow_code;
    logic [5:0]      shadow_dp;

    logic       time_ok_calc;
    logic [5:0] sec_calc, min_calc;

    logic [TW-1:0] tmo_cnt;

    // Enable stages reset to all-ones so the post-reset idle sample reads as blanking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_s1   <= '0;
            seg_s2   <= '0;
            seg_prev <= '0;
            dp_s1    <= 1'b0;
            dp_s2    <= 1'b0;
            dp_prev  <= 1'b0;
            enb_s1   <= '1;
            enb_s2   <= '1;
            enb_prev <= '1;
        end else begin
            seg_s1   <= i_seg;
            seg_s2   <= seg_s1;
            seg_prev <= seg_s2;
            dp_s1    <= i_seg_dp;
            dp_s2    <= dp_s1;
            dp_prev  <= dp_s2;
            enb_s1   <= i_seg_enb;
            enb_s2   <= enb_s1;
            enb_prev <= enb_s2;
        end
    end

    assign stable  = (seg_s2 == seg_prev) && (dp_s2 == dp_prev) && (enb_s2 == enb_prev);
    assign capture = stable && (stab_cnt == SETTLE_M1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stab_cnt <= '0;
        end else if (!stable) begin
            stab_cnt <= '0;
        end else if (stab_cnt != SETTLE_V) begin
            stab_cnt <= stab_cnt + 1'b1;
        end
    end

    always_comb begin
        seg_code = 4'hE;
        seg_bad  = 1'b0;
        case (seg_s2)
            7'h7E:   seg_code = 4'h0;
            7'h30:   seg_code = 4'h1;
            7'h6D:   seg_code = 4'h2;
            7'h79:   seg_code = 4'h3;
            7'h33:   seg_code = 4'h4;
            7'h5B:   seg_code = 4'h5;
            7'h5F:   seg_code = 4'h6;
            7'h70:   seg_code = 4'h7;
            7'h7F:   seg_code = 4'h8;
            7'h73:   seg_code = 4'h9;
            7'h00:   seg_code = 4'hF;
            default: seg_bad  = 1'b1;
        endcase
    end

    always_comb begin
        idx   = 3'd0;
        zeros = 3'd0;
        for (int unsigned k = 0; k < 6; k++) begin
            if (!enb_s2[k]) begin
                idx   = 3'(k);
                zeros = zeros + 3'd1;
            end
        end
        blank = (zeros == 3'd0);
        multi = (zeros > 3'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            exp_idx <= 3'd0;
        end else begin
            state   <= state_nxt;
            exp_idx <= exp_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        exp_nxt    = exp_idx;
        store      = 1'b0;
        err_nxt    = 1'b0;
        commit_nxt = 1'b0;
        if (capture && !blank) begin
            err_nxt = seg_bad;
            if (multi) begin
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (idx == 3'd0) begin
                            store     = 1'b1;
                            exp_nxt   = 3'd1;
                            state_nxt = COLLECT;
                        end
                    end
                    COLLECT: begin
                        if (idx == exp_idx) begin
                            store = 1'b1;
                            if (idx == 3'd5) begin
                                commit_nxt = 1'b1;
                                state_nxt  = IDLE;
                            end else begin
                                exp_nxt = exp_idx + 3'd1;
                            end
                        end else if (idx == 3'd0) begin
                            store   = 1'b1;
                            exp_nxt = 3'd1;
                            err_nxt = 1'b1;
                        end else begin
                            err_nxt   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                    default: state_nxt = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_code <= '1;
            shadow_dp   <= '0;
        end else if (store) begin
            shadow_code[idx] <= seg_code;
            shadow_dp[idx]   <= dp_s2;
        end
    end

    // Commit lags the capture edge by one clock, so an error pulse from the same
    // capture always lands in the cycle before o_frame_done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            commit_pend <= 1'b0;
        end else begin
            commit_pend <= commit_nxt;
        end
    end

    always_comb begin
        time_ok_calc = (shadow_code[0] <= 4'd9) && (shadow_code[1] <= 4'd5) &&
                       (shadow_code[2] <= 4'd9) && (shadow_code[3] <= 4'd5);
        sec_calc = ({2'b00, shadow_code[1]} << 3) + ({2'b00, shadow_code[1]} << 1) +
                   {2'b00, shadow_code[0]};
        min_calc = ({2'b00, shadow_code[3]} << 3) + ({2'b00, shadow_code[3]} << 1) +
                   {2'b00, shadow_code[2]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_digits     <= 24'hFFFFFF;
            o_dp         <= '0;
            o_sec        <= '0;
            o_min        <= '0;
            o_time_ok    <= 1'b0;
            o_frame_done <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_frame_done <= commit_pend;
            o_err        <= err_nxt;
            if (commit_pend) begin
                o_digits  <= shadow_code;
                o_dp      <= shadow_dp;
                o_time_ok <= time_ok_calc;
                if (time_ok_calc) begin
                    o_sec <= sec_calc;
                    o_min <= min_calc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt       <= '0;
            o_frame_valid <= 1'b0;
        end else if (commit_pend) begin
            tmo_cnt       <= '0;
            o_frame_valid <= 1'b1;
        end else if (tmo_cnt != TMAX) begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (tmo_cnt == TMAX_M1) begin
                o_frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_dec.sv
// Directed bench for seg_scan_dec: table of full-frame scans plus hand-written
// sequences for debounce, protocol errors, latency, timeout and mid-frame reset.
module tb_seg_scan_dec;

    localparam int unsigned T = 200;

    logic        clk;
    logic        rst_n;
    logic [6:0]  i_seg;
    logic        i_seg_dp;
    logic [5:0]  i_seg_enb;
    logic [23:0] o_digits;
    logic [5:0]  o_dp;
    logic [5:0]  o_sec;
    logic [5:0]  o_min;
    logic        o_time_ok;
    logic        o_frame_done;
    logic        o_frame_valid;
    logic        o_err;

    seg_scan_dec #(.SETTLE(4), .TIMEOUT(T)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_seg        (i_seg),
        .i_seg_dp     (i_seg_dp),
        .i_seg_enb    (i_seg_enb),
        .o_digits     (o_digits),
        .o_dp         (o_dp),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_time_ok    (o_time_ok),
        .o_frame_done (o_frame_done),
        .o_frame_valid(o_frame_valid),
        .o_err        (o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0][6:0] seg;
        logic [5:0]      dp;
        logic [23:0]     digits;
        logic [5:0]      sec;
        logic [5:0]      min;
        logic            ok;
        int unsigned     errs;
    } vec_t;

    vec_t vecs[7];

    int unsigned tests = 0;
    int unsigned fails = 0;
    int unsigned done_total = 0;
    int unsigned err_total = 0;
    int unsigned stretch = 0;
    logic        err_last = 1'b0;

    always @(negedge clk) begin
        if (o_frame_done) done_total++;
        if (o_err) err_total++;
        if (o_err && err_last) stretch++;
        err_last = o_err;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] enb_of(input int unsigned k);
        logic [5:0] e;
        e = '1;
        e[k] = 1'b0;
        return e;
    endfunction

    // Entered on a negedge; drives the bus and holds it n cycles, leaving on a negedge.
    task automatic show(input logic [6:0] seg, input logic dp, input logic [5:0] enb,
                        input int unsigned n);
        i_seg     = seg;
        i_seg_dp  = dp;
        i_seg_enb = enb;
        repeat (n) @(negedge clk);
    endtask

    task automatic scan(input logic [5:0][6:0] seg, input logic [5:0] dp);
        for (int unsigned k = 0; k < 6; k++) show(seg[k], dp[k], enb_of(k), 10);
        show(7'h00, 1'b0, 6'h3F, 20);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " digits"}, o_digits, 24'hFFFFFF);
        check({tag, " dp"}, o_dp, 6'h00);
        check({tag, " sec"}, o_sec, 6'd0);
        check({tag, " min"}, o_min, 6'd0);
        check({tag, " time_ok"}, o_time_ok, 1'b0);
        check({tag, " frame_done"}, o_frame_done, 1'b0);
        check({tag, " frame_valid"}, o_frame_valid, 1'b0);
        check({tag, " err"}, o_err, 1'b0);
    endtask

    initial begin
        int unsigned d0, e0, lat, k;
        logic        seen;
        logic [5:0][6:0] s1234, s5959;

        s1234 = {7'h00, 7'h00, 7'h30, 7'h6D, 7'h79, 7'h33};
        s5959 = {7'h73, 7'h7E, 7'h5B, 7'h73, 7'h5B, 7'h73};
        vecs[0] = '{seg: s1234, dp: 6'h00, digits: 24'hFF1234, sec: 6'd34, min: 6'd12, ok: 1'b1, errs: 0};
        vecs[1] = '{seg: {7'h00, 7'h00, 7'h5B, 7'h73, 7'h5F, 7'h73}, dp: 6'h00,
                    digits: 24'hFF5969, sec: 6'd34, min: 6'd12, ok: 1'b0, errs: 0};
        vecs[2] = '{seg: {7'h30, 7'h7F, 7'h7E, 7'h5B, 7'h7E, 7'h70}, dp: 6'b000100,
                    digits: 24'h180507, sec: 6'd7, min: 6'd5, ok: 1'b1, errs: 0};
        vecs[3] = '{seg: {7'h00, 7'h00, 7'h6D, 7'h01, 7'h7E, 7'h7E}, dp: 6'h00,
                    digits: 24'hFF2E00, sec: 6'd7, min: 6'd5, ok: 1'b0, errs: 1};
        vecs[4] = '{seg: s5959, dp: 6'h00, digits: 24'h905959, sec: 6'd59, min: 6'd59, ok: 1'b1, errs: 0};
        vecs[5] = '{seg: {7'h00, 7'h00, 7'h7E, 7'h7E, 7'h7E, 7'h7E}, dp: 6'h3F,
                    digits: 24'hFF0000, sec: 6'd0, min: 6'd0, ok: 1'b1, errs: 0};
        vecs[6] = '{seg: {7'h00, 7'h00, 7'h5F, 7'h7E, 7'h7E, 7'h7E}, dp: 6'h00,
                    digits: 24'hFF6000, sec: 6'd0, min: 6'd0, ok: 1'b0, errs: 0};

        rst_n     = 1'b0;
        i_seg     = 7'h00;
        i_seg_dp  = 1'b0;
        i_seg_enb = 6'h3F;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        show(7'h00, 1'b0, 6'h3F, 10);
        check("post-reset err count", err_total, 0);

        for (int unsigned i = 0; i < 7; i++) begin
            d0 = done_total;
            e0 = err_total;
            scan(vecs[i].seg, vecs[i].dp);
            check($sformatf("v%0d frame_done count", i), done_total - d0, 1);
            check($sformatf("v%0d err count", i), err_total - e0, vecs[i].errs);
            check($sformatf("v%0d digits", i), o_digits, vecs[i].digits);
            check($sformatf("v%0d dp", i), o_dp, vecs[i].dp);
            check($sformatf("v%0d sec", i), o_sec, vecs[i].sec);
            check($sformatf("v%0d min", i), o_min, vecs[i].min);
            check($sformatf("v%0d time_ok", i), o_time_ok, vecs[i].ok);
            check($sformatf("v%0d frame_valid", i), o_frame_valid, 1'b1);
        end

        // Digits held only 3 cycles never settle.
        d0 = done_total;
        e0 = err_total;
        for (int unsigned i = 0; i < 6; i++) show(s1234[i], 1'b0, enb_of(i), 3);
        show(7'h00, 1'b0, 6'h3F, 20);
        check("short hold frame_done", done_total - d0, 0);
        check("short hold err", err_total - e0, 0);
        check("short hold digits", o_digits, 24'hFF6000);

        // Order 0,1,3 errors without commit; the following full scan recovers.
        d0 = done_total;
        e0 = err_total;
        show(s1234[0], 1'b0, enb_of(0), 10);
        show(s1234[1], 1'b0, enb_of(1), 10);
        show(s1234[3], 1'b0, enb_of(3), 10);
        show(7'h00, 1'b0, 6'h3F, 20);
        check("skip err count", err_total - e0, 1);
        check("skip frame_done", done_total - d0, 0);
        d0 = done_total;
        scan(s1234, 6'h00);
        check("recover frame_done", done_total - d0, 1);
        check("recover digits", o_digits, 24'hFF1234);
        check("recover sec", o_sec, 6'd34);
        check("recover min", o_min, 6'd12);

        // Two enables low aborts; remaining digits 3..5 are discarded silently.
        d0 = done_total;
        e0 = err_total;
        show(s1234[0], 1'b0, enb_of(0), 10);
        show(s1234[1], 1'b0, enb_of(1), 10);
        show(7'h6D, 1'b0, 6'b111100, 10);
        for (int unsigned i = 3; i < 6; i++) show(s1234[i], 1'b0, enb_of(i), 10);
        show(7'h00, 1'b0, 6'h3F, 20);
        check("multi-enb err count", err_total - e0, 1);
        check("multi-enb frame_done", done_total - d0, 0);
        check("multi-enb digits", o_digits, 24'hFF1234);

        // Latency from driving digit 5 to o_frame_done, then timeout.
        d0 = done_total;
        e0 = err_total;
        for (int unsigned i = 0; i < 5; i++) show(s5959[i], 1'b0, enb_of(i), 10);
        i_seg     = s5959[5];
        i_seg_enb = enb_of(5);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            @(negedge clk);
            lat++;
            if (o_frame_done) seen = 1'b1;
        end
        check("digit5 to frame_done cycles", lat, 8);
        check("latency frame digits", o_digits, 24'h905959);
        k = 0;
        while (o_frame_valid && k < T + 50) begin
            @(negedge clk);
            k++;
        end
        check("frame_valid timeout cycles", k, T);
        check("frame_valid after timeout", o_frame_valid, 1'b0);
        check("latency run frame_done", done_total - d0, 1);
        check("latency run err", err_total - e0, 0);
        show(7'h00, 1'b0, 6'h3F, 10);

        // Fresh frame, then reset asynchronously mid-frame.
        scan(s1234, 6'b000011);
        check("pre-reset frame_valid", o_frame_valid, 1'b1);
        show(s1234[0], 1'b0, enb_of(0), 10);
        show(s1234[1], 1'b0, enb_of(1), 10);
        show(s1234[2], 1'b0, enb_of(2), 10);
        show(s1234[3], 1'b0, enb_of(3), 3);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        d0 = done_total;
        e0 = err_total;
        for (int unsigned i = 3; i < 6; i++) show(s1234[i], 1'b0, enb_of(i), 10);
        show(7'h00, 1'b0, 6'h3F, 20);
        check("partial after reset frame_done", done_total - d0, 0);
        check("partial after reset err", err_total - e0, 0);
        check("partial after reset digits", o_digits, 24'hFFFFFF);

        check("err pulse width", stretch, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
